dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 27 ++
 rtl/dmem_arb_pick.sv | 16 +
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared processor package: memory access size codes, arbiter FSM states
// and the size-to-byte-count helper used by the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam logic [2:0] MEM_BYTE_SIGNED       = 3'b000;
  localparam logic [2:0] MEM_HALFWORD_SIGNED   = 3'b001;
  localparam logic [2:0] MEM_WORD_SIGNED       = 3'b010;
  localparam logic [2:0] MEM_BYTE_UNSIGNED     = 3'b100;
  localparam logic [2:0] MEM_HALFWORD_UNSIGNED = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  // Bytes touched by a size code; 0 marks an unknown code.
  function automatic logic [2:0] size_nbytes(input logic [2:0] size);
    case (size)
      MEM_BYTE_SIGNED, MEM_BYTE_UNSIGNED:         size_nbytes = 3'd1;
      MEM_HALFWORD_SIGNED, MEM_HALFWORD_UNSIGNED: size_nbytes = 3'd2;
      MEM_WORD_SIGNED:                            size_nbytes = 3'd4;
      default:                                    size_nbytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection between the two requesters. A tie goes to the requester
// named by prio; the top decides how prio evolves (fixed or round-robin).
module dmem_arb_pick (
  input  logic [1:0] req_valid,
  input  logic       prio,
  output logic       any,
  output logic       idx
);

  // Single requester wins outright; on a tie the priority holder wins.
  always_comb begin
    any = |req_valid;
    idx = (&req_valid) ? prio : req_valid[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: IDLE -> ACCESS -> RESP, one access
// every 2 cycles, response 2 cycles after acceptance. Illegal sizes or
// out-of-range accesses never write and answer with err=1, rdata=0.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise requester 0
// always wins ties.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int MEM_BYTES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][31:0]       req_wdata,
  input  logic [1:0]             req_we,
  input  logic [1:0][2:0]        req_size,
  output logic [1:0]             resp_valid,
  output logic [31:0]            resp_rdata,
  output logic                   resp_err,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [31:0]            mem_wr_data,
  output logic                   mem_we,
  output logic [2:0]             mem_size,
  input  logic [31:0]            mem_rd_data
);

  arb_state_e        state_q, state_d;
  logic              prio_q, prio_d;
  logic              gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wr_data_q, mem_wr_data_d;
  logic [2:0]        mem_size_q, mem_size_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              pick_any, pick_idx;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_size;
  logic [2:0]        sel_nbytes;
  logic [31:0]       sel_end;
  logic              sel_legal;

  dmem_arb_pick u_pick (
    .req_valid (req_valid),
    .prio      (prio_q),
    .any       (pick_any),
    .idx       (pick_idx)
  );

  // Acceptance is open in IDLE and RESP only, and never while reset is low.
  always_comb begin
    accept     = rst && (state_q != ACCESS) && pick_any;
    req_ready  = accept ? (pick_idx ? 2'b10 : 2'b01) : 2'b00;
    sel_addr   = req_addr[pick_idx];
    sel_size   = req_size[pick_idx];
    sel_nbytes = size_nbytes(sel_size);
    sel_end    = 32'(sel_addr) + 32'(sel_nbytes);
    sel_legal  = (sel_nbytes != 3'd0) && (sel_end <= 32'(MEM_BYTES));
  end

  // Next-state logic; memory port and response outputs are all registered.
  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    gnt_d         = gnt_q;
    wr_d          = wr_q;
    err_d         = err_q;
    mem_addr_d    = '0;
    mem_wr_data_d = '0;
    mem_size_d    = '0;
    mem_we_d      = 1'b0;
    resp_valid_d  = 2'b00;
    resp_rdata_d  = resp_rdata_q;
    resp_err_d    = resp_err_q;
    case (state_q)
      ACCESS: begin
        state_d      = RESP;
        resp_valid_d = gnt_q ? 2'b10 : 2'b01;
        resp_rdata_d = (wr_q || err_q) ? 32'h0 : mem_rd_data;
        resp_err_d   = err_q;
      end
      default: begin
        if (accept) begin
          state_d       = ACCESS;
          gnt_d         = pick_idx;
          wr_d          = req_we[pick_idx];
          err_d         = !sel_legal;
          mem_addr_d    = sel_addr;
          mem_wr_data_d = req_wdata[pick_idx];
          mem_size_d    = sel_size;
          mem_we_d      = req_we[pick_idx] && sel_legal;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          prio_d        = ~pick_idx;
`else
          prio_d        = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      prio_q        <= 1'b0;
      gnt_q         <= 1'b0;
      wr_q          <= 1'b0;
      err_q         <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_size_q    <= '0;
      mem_we_q      <= 1'b0;
      resp_valid_q  <= 2'b00;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      gnt_q         <= gnt_d;
      wr_q          <= wr_d;
      err_q         <= err_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_size_q    <= mem_size_d;
      mem_we_q      <= mem_we_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_size    = mem_size_q;
  assign mem_we      = mem_we_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;

endmodule
